meas_calc: RTL and testbench
============================

# meas_calc

Sequential, parametrised result processor for the frequency meter. It turns the four raw gate-counter values into frequency, duty cycle, phase difference or raw period count. Each result is computed with one shared restoring divider over multiple cycles, and a START/DONE handshake frames every computation. It sits between the counter block and the display driver, and adds divide-by-zero and overflow detection with saturation.

## Interface
Parameters:
- CNT_W, 32, width of each counter input Q1..Q4.
- OUT_W, 32, width of DATA.
- REF_HZ, 100_000_000, reference clock frequency used for frequency scaling.
- MUL_W, 27, width of the scaling constants. Must satisfy REF_HZ < 2^MUL_W and 3600 < 2^MUL_W.
- NUM_W is derived: CNT_W + MUL_W (59 at defaults).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK, input, 1, system clock. All logic is on the rising edge.
- RST, input, 1, synchronous active-high reset.
- START, input, 1, request a computation. Sampled only in IDLE.
- SEL, input, 2, mode: 3 = frequency, 1 = duty, 2 = phase, 0 = raw period.
- Q1, input, CNT_W, reference-clock count over the measurement window (period base).
- Q2, input, CNT_W, signal edge count over the window.
- Q3, input, CNT_W, high-time count.
- Q4, input, CNT_W, phase-offset count.
- BUSY, output, 1, high whenever the state is not IDLE.
- DONE, output, 1, one-cycle pulse when DATA and ERR are updated.
- DATA, output, OUT_W, result. Holds its value until the next DONE.
- ERR, output, 1, divide-by-zero or overflow flag. Valid with DONE and held until the next DONE.

## Operation
- FSM states: IDLE, LOAD, DIV, FIN.
- IDLE → LOAD: on START=1. Q1..Q4 and SEL are latched on the same edge, so later input changes do not affect the computation.
- LOAD: forms the registered numerator and selects the denominator.
  - SEL=3: num = REF_HZ·Q2, den = Q1. Result in Hz.
  - SEL=1: num = 1000·Q3, den = Q1. Result in units of 0.1 %.
  - SEL=2: num = 3600·Q4, den = Q1. Result in units of 0.1°.
  - SEL=0: no division. Goes to FIN with DATA = Q1, saturated to OUT_W, and ERR=0.
  - den = 0 in modes 1, 2, 3: goes to FIN directly with DATA = all ones and ERR=1.
  - Otherwise goes to DIV.
- DIV: restoring division producing 1 quotient bit per cycle, MSB first, for exactly NUM_W cycles.
  - Partial remainder width is CNT_W+1; the quotient register is NUM_W wide.
  - After the last bit, the state goes to FIN.
- FIN (one cycle): DONE=1 and DATA/ERR are updated.
  - If the quotient is ≥ 2^OUT_W, DATA = all ones and ERR=1.
  - Otherwise DATA = the quotient truncated to OUT_W and ERR=0.
  - Next state is IDLE.
- Rounding: the quotient is floored and the remainder is discarded.
- START is ignored in LOAD, DIV and FIN; it is not queued.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, DATA=0, ERR=0. Internal registers are cleared.
- RST during any state aborts the computation. Outputs return to the reset values on the next edge, and there is no DONE for the aborted request.
- RST and START high together: RST wins.
- Latency, counted from the edge k that samples START:
  - Division modes: DONE is high in the cycle after edge k+NUM_W+2, which is 61 cycles at defaults.
  - SEL=0 and den=0 cases: DONE is high after edge k+2.
- BUSY rises after edge k and falls after the edge that leaves FIN. START can be accepted again on the first edge with BUSY=0.
- DONE is exactly one cycle wide. DATA and ERR change only on the edge that raises DONE, or on reset.
- Minimum request spacing: NUM_W+3 cycles in division modes; 3 cycles in the SEL=0 and den=0 cases.

## Test plan
- Frequency: SEL=3, Q1=100_000_000, Q2=1000 → DATA=1000, ERR=0. DONE exactly 61 cycles after the START edge. BUSY is high throughout.
- Duty and phase, back-to-back: SEL=1, Q1=400, Q3=100 → DATA=250 (25.0 %). Then SEL=2, Q1=1000, Q4=125 → DATA=450 (45.0°). Both ERR=0.
- Divide-by-zero and pass-through:
  - SEL=3, Q1=0 → DATA=0xFFFF_FFFF, ERR=1, DONE 2 cycles after START.
  - SEL=0, Q1=12345 → DATA=12345, ERR=0, DONE 2 cycles after START.
- Overflow: SEL=3, Q1=1, Q2=100 → quotient 10^10 > 2^32−1, so DATA=0xFFFF_FFFF and ERR=1.
- Busy protection: START with Q2=1000 (SEL=3, Q1=10^8). Then pulse START again 10 cycles later with Q2=5 and inputs changed → exactly one DONE, DATA=1000.
- Reset mid-operation: RST asserted 20 cycles into DIV → next cycle BUSY=0, DONE=0, DATA=0, ERR=0, and no DONE follows. A fresh START afterwards completes with the correct result.

Source files
------------

// File: rtl/meas_calc_if.sv
// meas_calc_if: request/result bundle between a measurement controller and meas_calc.
//   START  request a computation (sampled by meas_calc only when idle)
//   SEL    mode: 3 = frequency, 1 = duty, 2 = phase, 0 = raw period
//   Q1..Q4 raw gate-counter values (period base, edges, high time, phase offset)
//   BUSY   calculator is not idle
//   DONE   one-cycle pulse when DATA/ERR are updated
//   DATA   result, held until the next DONE
//   ERR    divide-by-zero or overflow, held until the next DONE
interface meas_calc_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned OUT_W = 32
);
    logic             START;
    logic [1:0]       SEL;
    logic [CNT_W-1:0] Q1;
    logic [CNT_W-1:0] Q2;
    logic [CNT_W-1:0] Q3;
    logic [CNT_W-1:0] Q4;
    logic             BUSY;
    logic             DONE;
    logic [OUT_W-1:0] DATA;
    logic             ERR;

    modport master (
        output START, SEL, Q1, Q2, Q3, Q4,
        input  BUSY, DONE, DATA, ERR
    );

    modport slave (
        input  START, SEL, Q1, Q2, Q3, Q4,
        output BUSY, DONE, DATA, ERR
    );
endinterface

// File: rtl/meas_calc.sv
// meas_calc: sequential result processor for the frequency meter.
// Scales one raw counter value by a constant and divides it by the period count Q1
// with a single restoring divider (one quotient bit per cycle), producing frequency,
// duty cycle, phase difference or the raw period, with divide-by-zero and overflow
// saturation.
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset, aborts any computation
//   bus  meas_calc_if slave: START/SEL/Q1..Q4 in, BUSY/DONE/DATA/ERR out
module meas_calc #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned REF_HZ = 100_000_000,
    parameter int unsigned MUL_W  = 27,
    parameter int unsigned NUM_W  = CNT_W + MUL_W
) (
    input  logic        CLK,
    input  logic        RST,
    meas_calc_if.slave  bus
);
    localparam int unsigned CW = $clog2(NUM_W + 1);

    localparam logic [MUL_W-1:0] REF_K   = MUL_W'(REF_HZ);
    localparam logic [MUL_W-1:0] DUTY_K  = MUL_W'(1000);
    localparam logic [MUL_W-1:0] PHASE_K = MUL_W'(3600);

    typedef enum logic [1:0] {StIdle, StLoad, StDiv, StFin} state_e;

    state_e state_q, state_d;

    logic [1:0]       sel_q;
    logic [CNT_W-1:0] q1_q, q2_q, q3_q, q4_q;
    logic [NUM_W-1:0] quo_q;     // holds the numerator, shifted out as quotient bits enter
    logic [CNT_W:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic             raw_q;     // pass-through mode: saturate without flagging
    logic             dz_q;      // divide by zero detected in LOAD
    logic             done_q;
    logic [OUT_W-1:0] data_q;
    logic             err_q;

    logic [CNT_W:0]   rem_sh;
    logic             ge;
    logic [CNT_W:0]   rem_d;
    logic [NUM_W-1:0] quo_d;
    logic             ovf;

    // One restoring step: bring in the next numerator bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem_q[CNT_W-1:0], quo_q[NUM_W-1]};
        ge     = (rem_sh >= {1'b0, q1_q});
        rem_d  = ge ? (rem_sh - {1'b0, q1_q}) : rem_sh;
        quo_d  = {quo_q[NUM_W-2:0], ge};
        ovf    = |(quo_q >> OUT_W);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.START) state_d = StLoad;
            StLoad: begin
                if (sel_q == 2'd0 || q1_q == '0) state_d = StFin;
                else                             state_d = StDiv;
            end
            StDiv:  if (cnt_q == CW'(NUM_W - 1)) state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_q  <= '0;
            q1_q   <= '0;
            q2_q   <= '0;
            q3_q   <= '0;
            q4_q   <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            raw_q  <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.START) begin
                        sel_q <= bus.SEL;
                        q1_q  <= bus.Q1;
                        q2_q  <= bus.Q2;
                        q3_q  <= bus.Q3;
                        q4_q  <= bus.Q4;
                    end
                end
                StLoad: begin
                    rem_q <= '0;
                    cnt_q <= '0;
                    raw_q <= (sel_q == 2'd0);
                    dz_q  <= (sel_q != 2'd0) && (q1_q == '0);
                    case (sel_q)
                        2'd3:    quo_q <= NUM_W'(q2_q) * NUM_W'(REF_K);
                        2'd1:    quo_q <= NUM_W'(q3_q) * NUM_W'(DUTY_K);
                        2'd2:    quo_q <= NUM_W'(q4_q) * NUM_W'(PHASE_K);
                        default: quo_q <= NUM_W'(q1_q);
                    endcase
                end
                StDiv: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                end
                StFin: begin
                    done_q <= 1'b1;
                    data_q <= (dz_q || ovf) ? '1 : quo_q[OUT_W-1:0];
                    err_q  <= dz_q || (ovf && !raw_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY = (state_q != StIdle);
    assign bus.DONE = done_q;
    assign bus.DATA = data_q;
    assign bus.ERR  = err_q;
endmodule

// File: tb/tb_meas_calc.sv
// tb_meas_calc: directed self-checking bench for meas_calc at default parameters.
module tb_meas_calc;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    meas_calc_if #(.CNT_W(32), .OUT_W(32)) bus ();

    meas_calc dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Caller sits just after an edge with the DUT idle; returns just after edge k.
    task automatic start_req(input logic [1:0] sel, input logic [31:0] q1, input logic [31:0] q2,
                             input logic [31:0] q3, input logic [31:0] q4);
        bus.START = 1'b1;
        bus.SEL   = sel;
        bus.Q1    = q1;
        bus.Q2    = q2;
        bus.Q3    = q3;
        bus.Q4    = q4;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
    endtask

    // Counts edges after edge k until DONE is seen; lat = -1 on timeout.
    task automatic wait_done(input int max_cyc, output int lat, output bit busy_drop);
        lat       = -1;
        busy_drop = 1'b0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                lat = n;
                break;
            end
            if (!bus.BUSY) busy_drop = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.START = 1'b1;
        bus.SEL = 2'd0;
        bus.Q1 = 32'd7;
        bus.Q2 = '0;
        bus.Q3 = '0;
        bus.Q4 = '0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, expected 0", bus.BUSY);
        end
        n_checks++;
        if (bus.DONE !== 1'b0 || bus.ERR !== 1'b0 || bus.DATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got done=%b err=%b data=%h, expected 0/0/0",
                     bus.DONE, bus.ERR, bus.DATA);
        end
        RST = 1'b0;
        bus.START = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_not_queued: got busy=%b, expected 0", bus.BUSY);
        end
    endtask

    task automatic test_freq();
        int lat;
        bit drop;
        start_req(2'd3, 32'd100_000_000, 32'd1000, 32'd0, 32'd0);
        n_checks++;
        if (bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL freq_busy_rise: got %b, expected 1", bus.BUSY);
        end
        wait_done(200, lat, drop);
        n_checks++;
        if (lat !== 61) begin
            n_fail++;
            $display("FAIL freq_latency: got %0d, expected 61", lat);
        end
        n_checks++;
        if (drop !== 1'b0) begin
            n_fail++;
            $display("FAIL freq_busy_held: got drop=%b, expected 0", drop);
        end
        n_checks++;
        if (bus.DATA !== 32'd1000 || bus.ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL freq_result: got data=%0d err=%b, expected 1000/0", bus.DATA, bus.ERR);
        end
        n_checks++;
        if (bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL freq_busy_at_done: got %b, expected 0", bus.BUSY);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.DONE !== 1'b0 || bus.DATA !== 32'd1000) begin
            n_fail++;
            $display("FAIL freq_done_width: got done=%b data=%0d, expected 0/1000",
                     bus.DONE, bus.DATA);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit drop;
        start_req(2'd1, 32'd400, 32'd0, 32'd100, 32'd0);
        wait_done(200, lat, drop);
        n_checks++;
        if (lat !== 61 || bus.DATA !== 32'd250 || bus.ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL duty_result: got lat=%0d data=%0d err=%b, expected 61/250/0",
                     lat, bus.DATA, bus.ERR);
        end
        // Issue the next request in the DONE cycle: the first cycle with BUSY low.
        start_req(2'd2, 32'd1000, 32'd0, 32'd0, 32'd125);
        wait_done(200, lat, drop);
        n_checks++;
        if (lat !== 61 || bus.DATA !== 32'd450 || bus.ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL phase_result: got lat=%0d data=%0d err=%b, expected 61/450/0",
                     lat, bus.DATA, bus.ERR);
        end
    endtask

    task automatic test_zero_and_raw();
        int lat;
        bit drop;
        start_req(2'd3, 32'd0, 32'd5, 32'd0, 32'd0);
        wait_done(20, lat, drop);
        n_checks++;
        if (lat !== 2 || bus.DATA !== 32'hFFFF_FFFF || bus.ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero: got lat=%0d data=%h err=%b, expected 2/ffffffff/1",
                     lat, bus.DATA, bus.ERR);
        end
        @(posedge CLK);
        #1;
        start_req(2'd0, 32'd12345, 32'd9, 32'd9, 32'd9);
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.DONE !== 1'b0 || bus.DATA !== 32'hFFFF_FFFF || bus.ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_outputs_held: got done=%b data=%h err=%b, expected 0/ffffffff/1",
                     bus.DONE, bus.DATA, bus.ERR);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.DONE !== 1'b1 || bus.DATA !== 32'd12345 || bus.ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_passthrough: got done=%b data=%0d err=%b, expected 1/12345/0",
                     bus.DONE, bus.DATA, bus.ERR);
        end
    endtask

    task automatic test_overflow();
        int lat;
        bit drop;
        @(posedge CLK);
        #1;
        start_req(2'd3, 32'd1, 32'd100, 32'd0, 32'd0);
        wait_done(200, lat, drop);
        n_checks++;
        if (lat !== 61 || bus.DATA !== 32'hFFFF_FFFF || bus.ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got lat=%0d data=%h err=%b, expected 61/ffffffff/1",
                     lat, bus.DATA, bus.ERR);
        end
    endtask

    task automatic test_busy_protect();
        int dones;
        int first_lat;
        logic [31:0] first_data;
        @(posedge CLK);
        #1;
        start_req(2'd3, 32'd100_000_000, 32'd1000, 32'd0, 32'd0);
        dones = 0;
        first_lat = -1;
        first_data = '0;
        for (int n = 1; n <= 140; n++) begin
            if (n == 10) begin
                bus.START = 1'b1;
                bus.Q1 = 32'd50_000_000;
                bus.Q2 = 32'd5;
            end else begin
                bus.START = 1'b0;
            end
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                dones++;
                if (first_lat < 0) begin
                    first_lat = n;
                    first_data = bus.DATA;
                end
            end
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL busy_protect_count: got %0d DONE pulses, expected 1", dones);
        end
        n_checks++;
        if (first_lat !== 61 || first_data !== 32'd1000) begin
            n_fail++;
            $display("FAIL busy_protect_result: got lat=%0d data=%0d, expected 61/1000",
                     first_lat, first_data);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        int lat;
        bit drop;
        start_req(2'd3, 32'd100_000_000, 32'd1000, 32'd0, 32'd0);
        repeat (21) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.DATA !== 32'h0 || bus.ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b data=%h err=%b, expected all 0",
                     bus.BUSY, bus.DONE, bus.DATA, bus.ERR);
        end
        dones = 0;
        repeat (80) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d DONE pulses, expected 0", dones);
        end
        start_req(2'd1, 32'd400, 32'd0, 32'd100, 32'd0);
        wait_done(200, lat, drop);
        n_checks++;
        if (lat !== 61 || bus.DATA !== 32'd250 || bus.ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got lat=%0d data=%0d err=%b, expected 61/250/0",
                     lat, bus.DATA, bus.ERR);
        end
    endtask

    initial begin
        test_reset();
        test_freq();
        test_back_to_back();
        test_zero_and_raw();
        test_overflow();
        test_busy_protect();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
